// File: rtl/systolic_mult_pkg.sv
// Shared types and sizing helpers for the systolic multiplier collector.
package systolic_mult_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT    = 2'd1,
        ST_COLLECT = 2'd2,
        ST_HOLD    = 2'd3
    } state_t;

    function automatic int product_width(input int width);
        return 2 * width;
    endfunction

    // Wide enough for both the delay countdown and the product bit index.
    function automatic int counter_width(input int first_bit_delay, input int width);
        int max_count;
        max_count = (first_bit_delay > product_width(width)) ? first_bit_delay : product_width(width);
        return $clog2(max_count + 1);
    endfunction

endpackage

// File: rtl/systolic_sipo_shift.sv
// Serial-in parallel-out register: shifts right, new bit enters at the MSB.
module systolic_sipo_shift #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         shift_en,
    input  logic         serial_in,
    output logic [W-1:0] data
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data <= '0;
        end else if (shift_en) begin
            data <= {serial_in, data[W-1:1]};
        end
    end

endmodule

// File: rtl/systolic_mult_collector.sv
// Deserialises the LSB-first product stream of the systolic array and offers
// the parallel product on a valid/ready handshake.
module systolic_mult_collector
    import systolic_mult_pkg::*;
#(
    parameter int WIDTH           = 8,
    parameter int FIRST_BIT_DELAY = 8
) (
    input  logic                                i_CLK,
    input  logic                                i_RST_N,
    input  logic                                i_START,
    input  logic                                i_SERIAL_BIT,
    input  logic                                i_READY,
    output logic [product_width(WIDTH)-1:0]     o_RESULT,
    output logic                                o_VALID,
    output logic                                o_BUSY,
    output logic                                o_OVERRUN,
    output logic [1:0]                          o_STATE
);

    localparam int PW = product_width(WIDTH);
    localparam int CW = counter_width(FIRST_BIT_DELAY, WIDTH);

    // Handshake: a product transfers on any edge where o_VALID and i_READY are
    // both high; o_RESULT is held unchanged for as long as o_VALID is high.

    state_t        state;
    logic [CW-1:0] delay_cnt;
    logic [CW-1:0] bit_cnt;
    logic          launch;
    logic          shift_en;

    // A start is accepted from IDLE, or from HOLD on the same edge the held
    // product is taken, so back-to-back products lose no cycle.
    assign launch   = i_START && ((state == ST_IDLE) || ((state == ST_HOLD) && i_READY));
    assign shift_en = (state == ST_COLLECT);
    assign o_STATE  = state;

    always_ff @(posedge i_CLK or negedge i_RST_N) begin
        if (!i_RST_N) begin
            state     <= ST_IDLE;
            delay_cnt <= '0;
            bit_cnt   <= '0;
            o_VALID   <= 1'b0;
            o_BUSY    <= 1'b0;
            o_OVERRUN <= 1'b0;
        end else begin
            o_OVERRUN <= 1'b0;
            if (launch) begin
                o_VALID <= 1'b0;
                o_BUSY  <= 1'b1;
                bit_cnt <= '0;
                if (FIRST_BIT_DELAY == 1) begin
                    state <= ST_COLLECT;
                end else begin
                    state     <= ST_WAIT;
                    delay_cnt <= CW'(FIRST_BIT_DELAY - 1);
                end
            end else begin
                unique case (state)
                    ST_IDLE: begin
                    end
                    ST_WAIT: begin
                        o_OVERRUN <= i_START;
                        delay_cnt <= delay_cnt - 1'b1;
                        if (delay_cnt == CW'(1)) begin
                            state   <= ST_COLLECT;
                            bit_cnt <= '0;
                        end
                    end
                    ST_COLLECT: begin
                        o_OVERRUN <= i_START;
                        if (bit_cnt == CW'(PW - 1)) begin
                            state   <= ST_HOLD;
                            o_VALID <= 1'b1;
                            o_BUSY  <= 1'b0;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                    ST_HOLD: begin
                        if (i_READY) begin
                            state   <= ST_IDLE;
                            o_VALID <= 1'b0;
                        end else begin
                            o_OVERRUN <= i_START;
                        end
                    end
                    default: begin
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    systolic_sipo_shift #(
        .W(PW)
    ) u_sipo (
        .clk       (i_CLK),
        .rst_n     (i_RST_N),
        .shift_en  (shift_en),
        .serial_in (i_SERIAL_BIT),
        .data      (o_RESULT)
    );

endmodule

// File: tb/tb_systolic_mult_collector.sv
// Bench for the product collector: a WIDTH=4/DELAY=4 instance for the main
// tests and a WIDTH=8/DELAY=1 instance for the minimum-delay case.
module tb_systolic_mult_collector;

    localparam int DA     = 4;
    localparam int PA     = 8;
    localparam int LAST_A = DA + PA - 1;
    localparam int DB     = 1;
    localparam int PB     = 16;

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_WAIT    = 2'd1;
    localparam logic [1:0] S_COLLECT = 2'd2;
    localparam logic [1:0] S_HOLD    = 2'd3;

    logic          clk;
    logic          rst_n;
    logic          a_start, a_bit, a_ready;
    logic [PA-1:0] a_result;
    logic          a_valid, a_busy, a_overrun;
    logic [1:0]    a_state;
    logic          b_start, b_bit, b_ready;
    logic [PB-1:0] b_result;
    logic          b_valid, b_busy, b_overrun;
    logic [1:0]    b_state;

    int            checks   = 0;
    int            failures = 0;
    logic [PA-1:0] exp_q[$];
    logic [PA-1:0] last_exp;

    typedef struct packed {
        logic [3:0] a;
        logic [3:0] b;
        logic [7:0] exp_p;
    } vec_t;
    vec_t vecs[8];

    systolic_mult_collector #(.WIDTH(4), .FIRST_BIT_DELAY(DA)) dut_a (
        .i_CLK(clk), .i_RST_N(rst_n), .i_START(a_start), .i_SERIAL_BIT(a_bit),
        .i_READY(a_ready), .o_RESULT(a_result), .o_VALID(a_valid), .o_BUSY(a_busy),
        .o_OVERRUN(a_overrun), .o_STATE(a_state)
    );

    systolic_mult_collector #(.WIDTH(8), .FIRST_BIT_DELAY(DB)) dut_b (
        .i_CLK(clk), .i_RST_N(rst_n), .i_START(b_start), .i_SERIAL_BIT(b_bit),
        .i_READY(b_ready), .o_RESULT(b_result), .o_VALID(b_valid), .o_BUSY(b_busy),
        .o_OVERRUN(b_overrun), .o_STATE(b_state)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Drive one product stream into dut_a following the timing contract: start
    // at edge 0, product bit k at edge DA+k. ovr_edge >= 1 pulses a stray start.
    task automatic collect_a(input logic [PA-1:0] bits, input int ovr_edge);
        logic [1:0] exp_state;
        a_start = 1'b1;
        a_bit   = 1'($urandom_range(0, 1));
        tick();
        a_start = 1'b0;
        check("a_launch_state", 32'(a_state), 32'(S_WAIT));
        check("a_launch_busy", 32'(a_busy), 32'd1);
        check("a_launch_valid", 32'(a_valid), 32'd0);
        for (int e = 1; e <= LAST_A; e++) begin
            a_start = (e == ovr_edge);
            if (e >= DA) a_bit = bits[e - DA];
            else         a_bit = 1'($urandom_range(0, 1));
            tick();
            if (e < DA - 1)       exp_state = S_WAIT;
            else if (e < LAST_A)  exp_state = S_COLLECT;
            else                  exp_state = S_HOLD;
            check("a_overrun", 32'(a_overrun), 32'(e == ovr_edge));
            check("a_busy", 32'(a_busy), 32'(e < LAST_A));
            check("a_valid", 32'(a_valid), 32'(e == LAST_A));
            check("a_state", 32'(a_state), 32'(exp_state));
        end
        a_start = 1'b0;
        if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL a_scoreboard: actual=%0h required=queued_product", a_result);
        end else begin
            last_exp = exp_q.pop_front();
            check("a_result", 32'(a_result), 32'(last_exp));
        end
    endtask

    // Keep dut_a in HOLD with ready low; a stray start on the third cycle.
    task automatic hold_a(input int n);
        for (int i = 0; i < n; i++) begin
            a_ready = 1'b0;
            a_start = (i == 2);
            tick();
            check("a_hold_valid", 32'(a_valid), 32'd1);
            check("a_hold_result", 32'(a_result), 32'(last_exp));
            check("a_hold_overrun", 32'(a_overrun), 32'(i == 2));
            check("a_hold_state", 32'(a_state), 32'(S_HOLD));
        end
        a_start = 1'b0;
    endtask

    task automatic release_a();
        a_ready = 1'b1;
        a_start = 1'b0;
        tick();
        check("a_rel_valid", 32'(a_valid), 32'd0);
        check("a_rel_state", 32'(a_state), 32'(S_IDLE));
        check("a_rel_result_kept", 32'(a_result), 32'(last_exp));
        tick();
        check("a_idle_busy", 32'(a_busy), 32'd0);
        check("a_idle_valid", 32'(a_valid), 32'd0);
    endtask

    initial begin
        logic [PA-1:0] prod;
        logic [15:0]   pb;
        logic [3:0]    ra, rb;
        int            ovr;

        vecs[0] = '{4'd13, 4'd11, 8'h8F};
        vecs[1] = '{4'd15, 4'd15, 8'hE1};
        vecs[2] = '{4'd0,  4'd0,  8'h00};
        vecs[3] = '{4'd15, 4'd1,  8'h0F};
        vecs[4] = '{4'd9,  4'd7,  8'h3F};
        vecs[5] = '{4'd12, 4'd10, 8'h78};
        vecs[6] = '{4'd1,  4'd1,  8'h01};
        vecs[7] = '{4'd8,  4'd8,  8'h40};

        rst_n = 1'b0;
        a_start = 1'b0; a_bit = 1'b0; a_ready = 1'b1;
        b_start = 1'b0; b_bit = 1'b0; b_ready = 1'b1;
        last_exp = '0;
        tick();
        tick();
        check("rst_a_result", 32'(a_result), 32'd0);
        check("rst_a_valid", 32'(a_valid), 32'd0);
        check("rst_a_busy", 32'(a_busy), 32'd0);
        check("rst_a_overrun", 32'(a_overrun), 32'd0);
        check("rst_a_state", 32'(a_state), 32'(S_IDLE));
        check("rst_b_result", 32'(b_result), 32'd0);
        check("rst_b_valid", 32'(b_valid), 32'd0);
        rst_n = 1'b1;
        tick();

        // 13*11 with ready high throughout
        exp_q.push_back(8'h8F);
        collect_a(8'h8F, -1);
        release_a();

        // Same product held for five cycles before acceptance
        exp_q.push_back(8'h8F);
        a_ready = 1'b0;
        collect_a(8'h8F, -1);
        hold_a(5);
        release_a();

        // Back-to-back: second start shares the transfer edge
        exp_q.push_back(8'h8F);
        collect_a(8'h8F, -1);
        exp_q.push_back(8'hE1);
        a_ready = 1'b1;
        collect_a(8'hE1, -1);
        release_a();

        // Stray start at edge 6 is dropped with a single overrun pulse
        exp_q.push_back(8'h8F);
        collect_a(8'h8F, 6);
        release_a();

        // Asynchronous reset after three product bits
        a_start = 1'b1;
        tick();
        a_start = 1'b0;
        for (int e = 1; e <= DA + 2; e++) begin
            a_bit = (e >= DA) ? 1'b1 : 1'b0;
            tick();
        end
        check("a_pre_rst_busy", 32'(a_busy), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("a_async_rst_result", 32'(a_result), 32'd0);
        check("a_async_rst_busy", 32'(a_busy), 32'd0);
        check("a_async_rst_valid", 32'(a_valid), 32'd0);
        check("a_async_rst_state", 32'(a_state), 32'(S_IDLE));
        #2 rst_n = 1'b1;
        tick();
        tick();
        check("a_post_rst_valid", 32'(a_valid), 32'd0);
        exp_q.push_back(8'h8F);
        collect_a(8'h8F, -1);
        release_a();

        // Table of operand pairs; stream driven from bench arithmetic
        for (int i = 0; i < 8; i++) begin
            prod = {4'b0, vecs[i].a} * {4'b0, vecs[i].b};
            exp_q.push_back(vecs[i].exp_p);
            collect_a(prod, (i % 3 == 1) ? (i + 2) : -1);
            if (i % 3 == 2) hold_a(3);
            if (i % 2 == 0 || i == 7) release_a();
            else a_ready = 1'b1;
        end

        // Randomized operands, holds, stray starts and back-to-back launches
        for (int i = 0; i < 20; i++) begin
            ra = 4'($urandom_range(0, 15));
            rb = 4'($urandom_range(0, 15));
            prod = {4'b0, ra} * {4'b0, rb};
            exp_q.push_back(prod);
            ovr = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, LAST_A)) : -1;
            collect_a(prod, ovr);
            hold_a(int'($urandom_range(0, 4)));
            if (i == 19 || $urandom_range(0, 1) == 1) release_a();
            else a_ready = 1'b1;
        end
        check("a_scoreboard_drained", 32'(exp_q.size()), 32'd0);

        // Minimum delay on the wide instance: bits at edges 1..16
        pb = 16'hA5C3;
        b_start = 1'b1;
        tick();
        b_start = 1'b0;
        check("b_launch_state", 32'(b_state), 32'(S_COLLECT));
        for (int e = 1; e <= PB; e++) begin
            b_bit = pb[e - 1];
            tick();
            check("b_valid", 32'(b_valid), 32'(e == PB));
            check("b_busy", 32'(b_busy), 32'(e < PB));
        end
        check("b_result", 32'(b_result), 32'h0000A5C3);
        check("b_overrun", 32'(b_overrun), 32'd0);
        tick();
        check("b_rel_valid", 32'(b_valid), 32'd0);
        check("b_rel_result_kept", 32'(b_result), 32'h0000A5C3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
